mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte-address width on the core and memory sides.
REQ-002 SHALL have parameter DATA_W, default 32: word width, fixed at 32 in this release.
REQ-003 SHALL have port Clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port Rst, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1: core request present.
REQ-006 SHALL have port req_ready, output, 1: controller can accept a request.
REQ-007 SHALL have port req_type, input, 2: 00 fetch, 01 load, 10 store; 11 is illegal.
REQ-008 SHALL have port req_size, input, 2: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-009 SHALL have port req_unsigned, input, 1: zero-extend loads when 1, sign-extend when 0.
REQ-010 SHALL have port req_addr, input, ADDR_W: byte address.
REQ-011 SHALL have port req_wdata, input, DATA_W: store data, right-aligned.
REQ-012 SHALL have port rsp_valid, output, 1: response present.
REQ-013 SHALL have port rsp_ready, input, 1: core accepts the response.
REQ-014 SHALL have port rsp_data, output, DATA_W: fetched instruction or extended load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err, output, 1: misaligned or illegal request.
REQ-016 SHALL have port mem_addr, output, ADDR_W: word-aligned byte address to memory, bits [1:0] always 0.
REQ-017 SHALL have port mem_wd, output, DATA_W: memory write data.
REQ-018 SHALL have port mem_we, output, 1: memory write enable; memory commits on the Clk edge while high.
REQ-019 SHALL have port mem_rdata, input, DATA_W: combinational data-word read at mem_addr.
REQ-020 SHALL have port mem_inst, input, DATA_W: combinational instruction-word read at mem_addr.

Function
REQ-021 SHALL implement FSM states IDLE, RD, WR, RSP; req_ready=1 only in IDLE.
REQ-022 SHALL latch type, size, unsigned, addr and wdata on the accepting edge (IDLE, req_valid=1).
REQ-023 SHALL classify as error: type 11, size 11, fetch with size!=10, half with addr[0]=1, word with addr[1:0]!=0; error goes IDLE->RSP with rsp_err=1, rsp_data=0, no mem_we.
REQ-024 SHALL route fetch and load IDLE->RD->RSP; rsp_valid first high 2 cycles after the accepting edge.
REQ-025 SHALL in RD sample mem_inst (fetch) or mem_rdata (load) into an internal buffer at the cycle-ending edge.
REQ-026 SHALL for load extract the byte or half selected by addr[1:0] or addr[1] and sign- or zero-extend per req_unsigned.
REQ-027 SHALL route store-word IDLE->WR->RSP, with mem_wd=wdata and mem_we=1 for exactly the WR cycle.
REQ-028 SHALL route store-byte and store-half IDLE->RD->WR->RSP (read-modify-write), merging wdata[7:0] or wdata[15:0] into the read word at the addressed lane and leaving other lanes unchanged.
REQ-029 SHALL drive mem_addr={addr[ADDR_W-1:2],2'b00} in RD and WR, and 0 with mem_we=0 in IDLE and RSP.
REQ-030 SHALL hold rsp_valid, rsp_data and rsp_err stable in RSP until rsp_ready=1, then return to IDLE on that edge.
REQ-031 SHALL not accept a new request in the cycle a response completes; the next accept occurs at the earliest from IDLE one cycle later.

Reset
REQ-032 SHALL on an edge with Rst=0 enter IDLE and clear all latches, with rsp_valid=0, rsp_err=0, rsp_data=0, mem_we=0, mem_addr=0 and mem_wd=0.
REQ-033 SHALL when reset lands mid-operation abort the operation with no response; a WR cycle coinciding with the reset edge commits its write, and no later write occurs.

Structure
REQ-034 SHALL take req_type codes, req_size codes and the FSM state encoding from the shared package mem_req_pkg.
REQ-035 SHALL place lane extraction, extension and store merge in one combinational sub-module, lane_merge.

Verification
REQ-036 SHALL cover: fetch at 0x20 with mem_inst=0xFEDFF28C -> rsp_valid 2 cycles after accept, rsp_data=0xFEDFF28C, rsp_err=0.
REQ-037 SHALL cover: signed load-byte at 0x0D with word 0x0000_8000 at 0x0C -> rsp_data=0xFFFF_FF80; the unsigned version -> 0x0000_0080.
REQ-038 SHALL cover: store-half 0xBEEF at 0x0A with word 0x1122_3344 at 0x08 -> one WR write of 0xBEEF_3344, then rsp_data=0.
REQ-039 SHALL cover: load-word at 0x06 -> rsp_err=1 on the cycle after accept, mem_we never high.
REQ-040 SHALL cover: rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable, req_ready=0 throughout.
REQ-041 SHALL cover: Rst=0 during RD of a store-byte -> no write, IDLE next cycle, all outputs at reset values.

Source files
------------

// File: rtl/mem_req_pkg.sv
// mem_req_pkg: request codes, FSM state encoding and request legality check
// Exports T_* request types, S_* access sizes, ST_* controller states and
// req_illegal(type, size, addr[1:0]).
package mem_req_pkg;
  localparam logic [1:0] T_FETCH = 2'b00, T_LOAD = 2'b01, T_STORE = 2'b10, T_BAD = 2'b11;
  localparam logic [1:0] S_BYTE = 2'b00, S_HALF = 2'b01, S_WORD = 2'b10, S_BAD = 2'b11;
  localparam logic [1:0] ST_IDLE = 2'b00, ST_RD = 2'b01, ST_WR = 2'b10, ST_RSP = 2'b11;
  function automatic logic req_illegal(input logic [1:0] t, input logic [1:0] s, input logic [1:0] off);
    return t == T_BAD || s == S_BAD || (t == T_FETCH && s != S_WORD) ||
           (s == S_HALF && off[0]) || (s == S_WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/lane_merge.sv
// lane_merge: load lane extraction/extension and store lane merge
// Ports: size/zext/off select the lane, word is the memory word read,
// wdata the right-aligned store data; ldata is the extended load result,
// mdata the word with the store lanes replaced.
module lane_merge
  import mem_req_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        zext,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mdata
);
  logic [31:0] shifted, mask, wrep;
  logic [15:0] half;
  assign shifted = word >> {off, 3'b000};
  assign half    = off[1] ? word[31:16] : word[15:0];
  assign ldata   = size == S_BYTE ? {{24{~zext & shifted[7]}}, shifted[7:0]} :
                   size == S_HALF ? {{16{~zext & half[15]}}, half} : word;
  // replicate the store data across all lanes, then let the mask pick the addressed one
  assign mask    = size == S_BYTE ? 32'h0000_00ff << {off, 3'b000} :
                   size == S_HALF ? (off[1] ? 32'hffff_0000 : 32'h0000_ffff) : 32'hffff_ffff;
  assign wrep    = size == S_BYTE ? {4{wdata[7:0]}} : size == S_HALF ? {2{wdata[15:0]}} : wdata;
  assign mdata   = (word & ~mask) | (wrep & mask);
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding core-to-memory access controller
// Core side: req_* handshake in (type/size/unsigned/addr/wdata), rsp_* out
// (data/err). Memory side: word-aligned mem_addr, mem_wd/mem_we write port,
// combinational mem_rdata/mem_inst reads. Sub-byte stores are read-modify-write.
module mem_access_ctrl
  import mem_req_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_type,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] mem_inst
);
  logic [1:0]        state, next_state, r_type, r_size;
  logic              r_zext, err_q, illegal;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, rd_buf, ldata, mdata;
  assign illegal = req_illegal(req_type, req_size, req_addr[1:0]);
  assign next_state = state == ST_IDLE ? (!req_valid ? ST_IDLE : illegal ? ST_RSP :
                                          (req_type == T_STORE && req_size == S_WORD) ? ST_WR : ST_RD) :
                      state == ST_RD   ? (r_type == T_STORE ? ST_WR : ST_RSP) :
                      state == ST_WR   ? ST_RSP : (rsp_ready ? ST_IDLE : ST_RSP);
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state   <= ST_IDLE;
      r_type  <= '0;
      r_size  <= '0;
      r_zext  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      rd_buf  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == ST_IDLE && req_valid) begin
        r_type  <= req_type;
        r_size  <= req_size;
        r_zext  <= req_unsigned;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        err_q   <= illegal;
      end
      if (state == ST_RD) rd_buf <= r_type == T_FETCH ? mem_inst : mem_rdata;
      state <= next_state;
    end
  end
  lane_merge u_lane (
    .size  (r_size),
    .zext  (r_zext),
    .off   (r_addr[1:0]),
    .word  (rd_buf),
    .wdata (r_wdata),
    .ldata (ldata),
    .mdata (mdata)
  );
  assign req_ready = state == ST_IDLE;
  assign rsp_valid = state == ST_RSP;
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_data  = (rsp_valid && !err_q && r_type != T_STORE) ? (r_type == T_FETCH ? rd_buf : ldata) : '0;
  assign mem_addr  = (state == ST_RD || state == ST_WR) ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem_we    = state == ST_WR;
  // a full-word mask makes mdata equal the store data, so word stores need no read
  assign mem_wd    = mem_we ? mdata : '0;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench with byte-level reference model
module tb_mem_access_ctrl;
  typedef struct packed {logic [31:0] d; logic e;} rsp_t;
  typedef struct packed {logic [31:0] a; logic [31:0] d;} wr_t;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_unsigned = 1'b0;
  logic [1:0]  req_type = '0, req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err, mem_we;
  logic [31:0] rsp_data, mem_addr, mem_wd, mem_rdata, mem_inst;
  logic [31:0] dmem [16];
  logic [31:0] imem [16];
  logic [31:0] ref_mem [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  int          ready_mode = 0;
  int          checks = 0, errors = 0, wr_count = 0;
  logic [31:0] last_data = '0, last_wd = '0;
  logic        last_err = 1'b0;
  rsp_t        exp_rsp [$];
  wr_t         exp_wr [$];
  mem_access_ctrl dut (
    .Clk(clk), .Rst(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_inst(mem_inst)
  );
  always #5 clk = ~clk;
  assign mem_rdata = dmem[mem_addr[5:2]];
  assign mem_inst  = imem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (mem_we) dmem[mem_addr[5:2]] <= mem_wd;
    else if (pl_en) dmem[pl_idx] <= pl_val;
  end
  always @(posedge clk) begin
    #2;
    rsp_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask
  // expected outcome of one request, computed lane by lane from the reference memory
  function automatic void model(input logic [1:0] t, input logic [1:0] s, input logic u,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] d, output logic e, output logic w, output logic [31:0] nw);
    int n;
    longint v;
    logic [31:0] old;
    old = ref_mem[a[5:2]];
    e = t == 2'd3 || s == 2'd3 || (t == 2'd0 && s != 2'd2) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
    d = '0;
    w = 1'b0;
    nw = old;
    if (!e) begin
      n = 1 << s;
      if (t == 2'd0) d = imem[a[5:2]];
      else if (t == 2'd1) begin
        v = (longint'(old) >> (8 * a[1:0])) & ((longint'(1) << (8 * n)) - 1);
        if (!u && v[8 * n - 1]) v = v - (longint'(1) << (8 * n));
        d = v[31:0];
      end else begin
        w = 1'b1;
        for (int i = 0; i < n; i++) nw[8 * (a[1:0] + i) +: 8] = wd[8 * i +: 8];
      end
    end
  endfunction
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid && rsp_ready) begin
        last_data = rsp_data;
        last_err  = rsp_err;
        if (exp_rsp.size() == 0) fail_now("rsp_unexpected");
        else begin
          rsp_t x;
          x = exp_rsp.pop_front();
          chk("rsp_data", rsp_data, x.d);
          chk("rsp_err", 32'(rsp_err), 32'(x.e));
        end
      end
      if (mem_we) begin
        wr_count++;
        last_wd = mem_wd;
        if (exp_wr.size() == 0) fail_now("write_unexpected");
        else begin
          wr_t y;
          y = exp_wr.pop_front();
          chk("mem_addr", mem_addr, y.a);
          chk("mem_wd", mem_wd, y.d);
        end
      end
    end
  end
  task automatic poke(input int idx, input logic [31:0] val);
    pl_en = 1'b1;
    pl_idx = 4'(idx);
    pl_val = val;
    ref_mem[idx] = val;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask
  task automatic issue(input logic [1:0] t, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input bit abort);
    int b;
    logic [31:0] d, nw;
    logic e, w;
    b = 0;
    @(posedge clk);
    #1;
    while (!req_ready && b < 60) begin
      @(posedge clk);
      #1;
      b++;
    end
    if (!req_ready) begin
      fail_now("accept_timeout");
      return;
    end
    req_valid = 1'b1;
    req_type = t;
    req_size = s;
    req_unsigned = u;
    req_addr = a;
    req_wdata = wd;
    if (!abort) begin
      model(t, s, u, a, wd, d, e, w, nw);
      exp_rsp.push_back({d, e});
      if (w) begin
        exp_wr.push_back({{a[31:2], 2'b00}, nw});
        ref_mem[a[5:2]] = nw;
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int b;
    b = 0;
    while ((exp_rsp.size() != 0 || !req_ready) && b < 300) begin
      @(posedge clk);
      #1;
      b++;
    end
    if (exp_rsp.size() != 0 || !req_ready) fail_now("drain_timeout");
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wd"}, mem_wd, 32'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int w0;
    logic [31:0] snap;
    logic [1:0] t, s;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) imem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) poke(i, $urandom);
    // fetch latency and data
    imem[8] = 32'hFEDF_F28C;
    issue(2'd0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0);
    chk("fetch_not_yet_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 chk("fetch_valid_2cyc", 32'(rsp_valid), 32'd1);
    chk("fetch_data", rsp_data, 32'hFEDF_F28C);
    wait_idle();
    // signed and unsigned load-byte
    poke(3, 32'h0000_8000);
    issue(2'd1, 2'd0, 1'b0, 32'h0D, 32'h0, 1'b0);
    wait_idle();
    chk("lb_signed", last_data, 32'hFFFF_FF80);
    issue(2'd1, 2'd0, 1'b1, 32'h0D, 32'h0, 1'b0);
    wait_idle();
    chk("lb_unsigned", last_data, 32'h0000_0080);
    // store-half read-modify-write
    poke(2, 32'h1122_3344);
    w0 = wr_count;
    issue(2'd2, 2'd1, 1'b0, 32'h0A, 32'h0000_BEEF, 1'b0);
    wait_idle();
    chk("sh_write_count", 32'(wr_count - w0), 32'd1);
    chk("sh_write_data", last_wd, 32'hBEEF_3344);
    chk("sh_rsp_data", last_data, 32'd0);
    // misaligned load-word
    w0 = wr_count;
    issue(2'd1, 2'd2, 1'b0, 32'h06, 32'h0, 1'b0);
    chk("lw_err_valid", 32'(rsp_valid), 32'd1);
    chk("lw_err_flag", 32'(rsp_err), 32'd1);
    wait_idle();
    chk("lw_err_no_write", 32'(wr_count - w0), 32'd0);
    // response backpressure
    ready_mode = 2;
    issue(2'd1, 2'd2, 1'b0, 32'h14, 32'h0, 1'b0);
    w0 = 0;
    while (!rsp_valid && w0 < 20) begin
      @(posedge clk);
      #1 w0++;
    end
    if (!rsp_valid) fail_now("hold_rsp_timeout");
    snap = rsp_data;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", rsp_data, snap);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    ready_mode = 0;
    wait_idle();
    // reset during RD of a store-byte
    w0 = wr_count;
    issue(2'd2, 2'd0, 1'b0, 32'h11, 32'h0000_00A5, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 chk_reset_outputs("abort");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("abort_no_write", 32'(wr_count - w0), 32'd0);
    // randomized traffic with random backpressure
    ready_mode = 1;
    for (int k = 0; k < 150; k++) begin
      t = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      s = $urandom_range(0, 9) == 0 ? 2'd3 : (t == 2'd0 ? 2'd2 : 2'($urandom_range(0, 2)));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = s == 2'd2 ? 2'b00 : s == 2'd1 ? {a[1], 1'b0} : a[1:0];
      issue(t, s, 1'($urandom_range(0, 1)), a, $urandom, 1'b0);
    end
    ready_mode = 0;
    wait_idle();
    chk("writes_drained", 32'(exp_wr.size()), 32'd0);
    for (int i = 0; i < 16; i++) chk("mem_final", dmem[i], ref_mem[i]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
